// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative signed 32-bit multiply/divide unit (MIPS mult/div semantics).
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle on operand magnitudes, 32 steps, then a sign-fix cycle that writes
// the HI/LO registers.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start_mult request signed multiply (sampled only in IDLE, wins over div)
//   start_div  request signed divide   (sampled only in IDLE)
//   a, b       operands rs / rt, captured at the start edge
//   hi, lo     HI/LO result registers
//   busy       operation in flight
//   done       one-cycle pulse: hi/lo just updated
//   div_zero   one-cycle pulse: divide by zero trapped
//
// Configuration
//   MULTDIV_DIV_ZERO_TRAP_EN  when defined, a divide with b == 0 skips the
//   iteration, pulses done+div_zero one cycle after the start edge and
//   leaves hi/lo untouched. When undefined, div_zero is tied low and a
//   divide by zero runs the normal 33-cycle sequence.
// ---------------------------------------------------------------------------
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_opa;     // multiplicand magnitude / dividend magnitude (shifts left in DIV)
    logic [31:0] r_opb;     // multiplier magnitude (shifts right in MULT) / divisor magnitude
    logic [63:0] r_acc;     // MULT: running product; DIV: {remainder, quotient}
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_q;   // product / quotient must be negated
    logic        r_neg_r;   // remainder takes the dividend's sign
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    logic        w_go_mult;
    logic        w_go_div;
    logic        w_go_trap;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_madd;
    logic [31:0] w_rsh;
    logic [32:0] w_dsub;
    logic        w_qbit;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_go_mult = (r_state == S_IDLE) && start_mult;
    assign w_go_div  = (r_state == S_IDLE) && !start_mult && start_div;

`ifdef MULTDIV_DIV_ZERO_TRAP_EN
    logic r_trap;
    logic r_dz;
    assign w_go_trap = w_go_div && (b == 32'd0);
    assign div_zero  = r_dz;
`else
    assign w_go_trap = 1'b0;
    assign div_zero  = 1'b0;
`endif

    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign w_a_mag = a[31] ? (32'd0 - a) : a;
    assign w_b_mag = b[31] ? (32'd0 - b) : b;

    // Multiply step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole product right by one.
    assign w_madd = {1'b0, r_acc[63:32]} + {1'b0, (r_opb[0] ? r_opa : 32'd0)};

    // Divide step: shift the next dividend bit into the partial remainder and
    // trial-subtract the divisor. The remainder stays below the divisor
    // (<= 2^31), so dropping r_acc[63] on the shift loses nothing.
    assign w_rsh  = {r_acc[62:32], r_opa[31]};
    assign w_dsub = {1'b0, w_rsh} - {1'b0, r_opb};
    assign w_qbit = !w_dsub[32];

    // Sign correction applied in FIX
    assign w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
    assign w_quo  = r_neg_q ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
    assign w_rem  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go_mult)      w_next = S_MULT;
                else if (w_go_trap) w_next = S_FIX;
                else if (w_go_div)  w_next = S_DIV;
            end
            S_MULT:  if (r_cnt == 5'd31) w_next = S_FIX;
            S_DIV:   if (r_cnt == 5'd31) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_opa    <= 32'd0;
            r_opb    <= 32'd0;
            r_acc    <= 64'd0;
            r_cnt    <= 5'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef MULTDIV_DIV_ZERO_TRAP_EN
            r_trap   <= 1'b0;
            r_dz     <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
`ifdef MULTDIV_DIV_ZERO_TRAP_EN
            r_dz    <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_go_mult || w_go_div) begin
                        r_opa    <= w_a_mag;
                        r_opb    <= w_b_mag;
                        r_acc    <= 64'd0;
                        r_cnt    <= 5'd0;
                        r_is_div <= w_go_div;
                        r_neg_q  <= a[31] ^ b[31];
                        r_neg_r  <= a[31];
                        r_busy   <= 1'b1;
`ifdef MULTDIV_DIV_ZERO_TRAP_EN
                        r_trap   <= w_go_trap;
`endif
                    end
                end
                S_MULT: begin
                    r_acc <= {w_madd, r_acc[31:1]};
                    r_opb <= {1'b0, r_opb[31:1]};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_DIV: begin
                    r_acc <= {(w_qbit ? w_dsub[31:0] : w_rsh), r_acc[30:0], w_qbit};
                    r_opa <= {r_opa[30:0], 1'b0};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_FIX: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
`ifdef MULTDIV_DIV_ZERO_TRAP_EN
                    if (r_trap) begin
                        r_dz   <= 1'b1;
                        r_trap <= 1'b0;
                    end else
`endif
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult, start_div;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    int checks = 0;
    int errors = 0;

    // Architectural HI/LO as the reference model sees them
    logic [31:0] exp_hi, exp_lo;

    mult_div_unit dut (
        .clk(clk), .reset(reset),
        .start_mult(start_mult), .start_div(start_div),
        .a(a), .b(b),
        .hi(hi), .lo(lo),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model: plain 64-bit signed arithmetic
    task automatic model(input bit m, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, p, q, r;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (m) begin
            p  = sa * sb;
            eh = p[63:32];
            el = p[31:0];
        end else if (bv == 32'd0) begin
            eh = av;
            el = av[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            eh = r[31:0];
            el = q[31:0];
        end
    endtask

    // Called just after an active edge. Issues a request, follows the
    // 33-cycle sequence and checks busy/done timing and the result.
    // glitch > 0 pulses start_div (with junk operands) at edge E<glitch>.
    task automatic run_op(input bit sm, input bit sd, input logic [31:0] av,
                          input logic [31:0] bv, input int glitch, input string tag);
        logic [31:0] eh, el;
        bit ok;
        bit m;
        m = sm;
        start_mult = sm; start_div = sd; a = av; b = bv;
        @(posedge clk); #1;                       // E0
        start_mult = 1'b0; start_div = 1'b0;
        a = $urandom; b = $urandom;               // operands must no longer matter
`ifdef MULTDIV_DIV_ZERO_TRAP_EN
        if (!m && bv == 32'd0) begin
            @(posedge clk); #1;                   // E1
            chk({tag, ".dz_done"}, {63'd0, done}, 64'd1);
            chk({tag, ".dz_flag"}, {63'd0, div_zero}, 64'd1);
            chk({tag, ".dz_busy"}, {63'd0, busy}, 64'd0);
            chk({tag, ".dz_hilo"}, {hi, lo}, {exp_hi, exp_lo});
            return;
        end
`endif
        model(m, av, bv, eh, el);
        ok = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            if (busy !== 1'b1 || done !== 1'b0 || div_zero !== 1'b0) ok = 1'b0;
            if (k == glitch) begin start_div = 1'b1; a = $urandom; b = $urandom; end
            @(posedge clk); #1;
            start_div = 1'b0;
        end
        chk({tag, ".busy_window"}, {63'd0, ok}, 64'd1);
        chk({tag, ".done"}, {62'd0, busy, done}, 64'd1);
        chk({tag, ".div_zero"}, {63'd0, div_zero}, 64'd0);
        chk({tag, ".hilo"}, {hi, lo}, {eh, el});
        exp_hi = eh; exp_lo = el;
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit ok;
        reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; a = '0; b = '0;
        exp_hi = '0; exp_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.hilo", {hi, lo}, 64'd0);
        chk("reset.flags", {61'd0, busy, done, div_zero}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(1, 0, 32'h0000_0007, 32'hFFFF_FFFD, 0, "mul_7_m3");
        run_op(0, 1, 32'hFFFF_FFF9, 32'h0000_0002, 0, "div_m7_2");
        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0, "mul_min_min");
        run_op(1, 0, 32'h1234_5678, 32'hFEDC_BA98, 10, "mul_ignore_div");
        run_op(1, 1, 32'hFFFF_FFF0, 32'h0000_0003, 0, "both_starts");

        // hold: done drops, hi/lo keep their value
        @(posedge clk); #1;
        chk("hold.done", {63'd0, done}, 64'd0);
        chk("hold.hilo", {hi, lo}, {exp_hi, exp_lo});

        // reset in the middle of a divide
        start_div = 1'b1; a = 32'h0000_1000; b = 32'h0000_0007;
        @(posedge clk); #1;
        start_div = 1'b0;
        repeat (15) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst.hilo", {hi, lo}, 64'd0);
        chk("midrst.flags", {62'd0, busy, done}, 64'd0);
        exp_hi = '0; exp_lo = '0;
        @(negedge clk) reset = 1'b0;
        ok = 1'b1;
        repeat (25) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("midrst.no_done", {63'd0, ok}, 64'd1);
        run_op(0, 1, 32'hFFFF_FF9C, 32'h0000_0007, 0, "after_rst");

        run_op(0, 1, 32'h0000_0005, 32'h0000_0000, 0, "div_zero_pos");
        run_op(0, 1, 32'hFFFF_FFFB, 32'h0000_0000, 0, "div_zero_neg");

        // randomized back-to-back operations
        for (int i = 0; i < 24; i++) begin
            ra = (i % 3 == 0) ? $urandom_range(0, 255) : $urandom;
            rb = (i % 4 == 1) ? (32'd0 - $urandom_range(1, 100)) : $urandom;
            if (i % 2 == 1 && rb == 32'd0) rb = 32'd1;
            run_op(i % 2 == 0, i % 2 == 1, ra, rb, 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Iterative signed 32-bit multiply/divide unit for the multicycle datapath.
- Accepts a start request from the control unit, performs MIPS `mult`/`div` semantics over 32 iteration cycles, and holds the result in internal HI/LO registers.
- HI/LO feed the write-back source select multiplexer (`mfhi`/`mflo` inputs).
- Raises `busy` so the control FSM can stall while an operation is in flight.

## Interface

Parameters: none (width fixed at 32).

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start_mult  input  1  request signed multiply; sampled only in IDLE
- start_div  input  1  request signed divide; sampled only in IDLE
- a  input  32  operand rs (multiplicand / dividend), captured at start
- b  input  32  operand rt (multiplier / divisor), captured at start
- hi  output  32  HI register (product[63:32] / remainder)
- lo  output  32  LO register (product[31:0] / quotient)
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse: hi/lo just updated
- div_zero  output  1  one-cycle pulse: divide by zero trapped (see Configuration)

## Operation

- FSM states: IDLE, MULT, DIV, FIX.
- IDLE, on `start_mult`:
  - capture |a|, |b| and the result sign;
  - clear the 64-bit accumulator and the 5-bit counter;
  - go to MULT.
- IDLE, on `start_div`: same capture, then go to DIV.
- `start_mult` and `start_div` both high: multiply wins; the divide request is dropped.
- Start while not IDLE: ignored, no queuing.
- MULT: one shift-add step per cycle on magnitudes; after 32 steps (counter 31) go to FIX.
- DIV: one restoring shift-subtract step per cycle on magnitudes; after 32 steps go to FIX.
- FIX: apply sign correction, write hi/lo, pulse done, return to IDLE.
- Multiply result:
  - {hi, lo} = full 64-bit two's-complement product of signed a and b.
- Divide result:
  - lo = quotient truncated toward zero;
  - hi = remainder, with the sign of the dividend (or zero).
  - Overflow case 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (32-bit wrap, no flag).
- Operand inputs may change after the start edge without effect.
- hi/lo hold their values until the next FIX, or until reset.
- Reset (any time, including mid-operation):
  - state IDLE;
  - hi = 0, lo = 0;
  - busy = 0, done = 0, div_zero = 0;
  - accumulator and counter cleared;
  - the in-flight result is discarded.

## Timing

- E0 is the rising edge sampling a valid start in IDLE.
- busy is high in the cycles after E0 through E33; it drops at E33.
- E1..E32: the 32 iteration cycles.
- E33: FIX. hi/lo take new values, done = 1 for exactly the following cycle, busy = 0.
- Latency: 33 cycles from the start edge to result visible.
- Back-to-back: a start sampled on the edge after E33 (done high) is accepted, giving 34 cycles per operation.
- busy and done are never high together.
- All outputs are registered; none is combinationally dependent on inputs.

## Configuration

- Macro: `MULTDIV_DIV_ZERO_TRAP_EN`.
- Defined:
  - `start_div` with b == 0 skips iteration;
  - at E1: done = 1 and div_zero = 1 for one cycle, busy = 0 for that cycle;
  - hi/lo unchanged.
- Not defined:
  - div_zero is tied to 0;
  - divide by zero runs the full 33 cycles;
  - result: hi = a, lo = (a negative ? 0x00000001 : 0xFFFFFFFF).

## Test plan

- Multiply, a = 0x00000007, b = 0xFFFFFFFD (−3) → at E33: hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, done pulses once, busy high E0–E33.
- Divide, a = 0xFFFFFFF9 (−7), b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- Divide overflow, a = 0x80000000, b = 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- Multiply 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
- Start handling:
  - start_div pulsed at E10 of a running multiply → ignored;
  - start_mult and start_div together in IDLE → multiply performed.
- Reset mid-operation:
  - reset at E15 of a divide → immediately hi = lo = 0, busy = 0, no done;
  - next start then completes normally in 33 cycles.
- Divide by zero, a = 5, b = 0:
  - with macro: done and div_zero at E1, hi/lo unchanged;
  - without macro: at E33, hi = 5, lo = 0xFFFFFFFF.
